// File: rtl/flash_core_pkg.sv
// Shared types and constants for the flash core front-end.
// Unlock/opcode values and FSM state encoding.
package flash_core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNLK1,
    UNLK2,
    RD_ARM,
    RD_DRV,
    WR_ARM,
    PROGRAM
  } fc_state_t;

  localparam logic [15:0] UNLK_ADDR1 = 16'h5555;
  localparam logic [7:0]  UNLK_DATA1 = 8'hAA;
  localparam logic [15:0] UNLK_ADDR2 = 16'hAAAA;
  localparam logic [7:0]  UNLK_DATA2 = 8'h55;

  localparam logic [7:0]  OP_READ    = 8'h10;
  localparam logic [7:0]  OP_WRITE   = 8'h20;

endpackage

// File: rtl/flash_mem_array.sv
// Single-port byte array, registered read.
// FC_PROG_AND_EN selects flash-style AND programming over plain overwrite.
module flash_mem_array #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
`ifdef FC_PROG_AND_EN
      mem[addr] <= mem[addr] & wdata;
`else
      mem[addr] <= wdata;
`endif
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/flash_core_cmd_ctrl.sv
// Flash core command front-end: bus sync, unlock decode, array access.
// FC_PROG_AND_EN (see flash_mem_array) selects AND-style programming.
module flash_core_cmd_ctrl
  import flash_core_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              fc_clk,
  input  logic              fc_rst,
  input  logic              nEN,
  input  logic              nWE,
  input  logic              nRE,
  input  logic              nReset,
  input  logic [ADDR_W-1:0] Addr,
  inout  wire  [7:0]        IO,
  output logic              fc_busy
);

  localparam int BW = 4 + ADDR_W + 8;
  localparam logic [BW-1:0] BUS_IDLE =
    {4'hF, {(ADDR_W+8){1'b0}}};

  // Whole bus shares one pipeline so address/data stay aligned to strobes
  logic [BW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge fc_clk) begin
    if (fc_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= BUS_IDLE;
    end else begin
      sync_q[0] <= {nEN, nWE, nRE, nReset, Addr, IO};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  logic              s_en;
  logic              s_we;
  logic              s_re;
  logic              s_rst;
  logic [ADDR_W-1:0] s_addr;
  logic [7:0]        s_io;

  assign {s_en, s_we, s_re, s_rst, s_addr, s_io} =
    sync_q[SYNC_STAGES-1];

  logic p_en;
  logic p_we;
  logic p_re;

  always_ff @(posedge fc_clk) begin
    if (fc_rst) begin
      p_en <= 1'b1;
      p_we <= 1'b1;
      p_re <= 1'b1;
    end else begin
      p_en <= s_en;
      p_we <= s_we;
      p_re <= s_re;
    end
  end

  logic wr_cyc;
  logic rd_cyc;
  logic en_fall;
  logic both_low;

  assign wr_cyc   = s_we & ~p_we & ~s_en;
  assign rd_cyc   = ~s_re & p_re & ~s_en;
  assign en_fall  = ~s_en & p_en;
  assign both_low = ~s_we & ~s_re;

  logic hit_u1;
  logic hit_u2;
  logic hit_rd;
  logic hit_wr;

  assign hit_u1 = (s_addr == ADDR_W'(UNLK_ADDR1))
                & (s_io == UNLK_DATA1);
  assign hit_u2 = (s_addr == ADDR_W'(UNLK_ADDR2))
                & (s_io == UNLK_DATA2);
  assign hit_rd = (s_addr == ADDR_W'(UNLK_ADDR1))
                & (s_io == OP_READ);
  assign hit_wr = (s_addr == ADDR_W'(UNLK_ADDR1))
                & (s_io == OP_WRITE);

  fc_state_t         state;
  logic              drv;
  logic [ADDR_W-1:0] pa;
  logic [7:0]        pd;

  always_ff @(posedge fc_clk) begin
    if (fc_rst) begin
      state   <= IDLE;
      drv     <= 1'b0;
      fc_busy <= 1'b0;
      pa      <= '0;
      pd      <= '0;
    end else begin
      fc_busy <= 1'b0;
      if (!s_rst || both_low) begin
        state <= IDLE;
        drv   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (wr_cyc && hit_u1) state <= UNLK1;
          end
          UNLK1: begin
            if (wr_cyc) state <= hit_u2 ? UNLK2 : IDLE;
          end
          UNLK2: begin
            if (wr_cyc) begin
              unique case (1'b1)
                hit_rd:  state <= RD_ARM;
                hit_wr:  state <= WR_ARM;
                default: state <= IDLE;
              endcase
            end
          end
          RD_ARM: begin
            if (rd_cyc) begin
              state <= RD_DRV;
              drv   <= 1'b1;
            end else if (wr_cyc) begin
              state <= IDLE;
            end
          end
          RD_DRV: begin
            if (en_fall) begin
              state <= IDLE;
              drv   <= 1'b0;
            end
          end
          WR_ARM: begin
            if (wr_cyc) begin
              pa      <= s_addr;
              pd      <= s_io;
              state   <= PROGRAM;
              fc_busy <= 1'b1;
            end else if (rd_cyc) begin
              state <= IDLE;
            end
          end
          PROGRAM: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  assign mem_we   = (state == PROGRAM);
  assign mem_re   = (state == RD_ARM) & rd_cyc
                  & s_rst & ~both_low;
  assign mem_addr = mem_we ? pa : s_addr;

  flash_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (fc_clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (pd),
    .rdata (mem_rdata)
  );

  assign IO = drv ? mem_rdata : 8'hzz;

endmodule

// File: tb/tb_flash_core_cmd_ctrl.sv
// Directed bench for flash_core_cmd_ctrl.
// IO is pulled up, so a released bus reads 8'hFF.
module tb_flash_core_cmd_ctrl;
  import flash_core_pkg::*;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        nEN    = 1'b1;
  logic        nWE    = 1'b1;
  logic        nRE    = 1'b1;
  logic        nReset = 1'b1;
  logic [15:0] Addr   = '0;
  logic        tb_oe  = 1'b0;
  logic [7:0]  tb_d   = '0;
  logic        mon    = 1'b0;
  wire  [7:0]  io_bus;
  wire         fc_busy;

  int vec   = 0;
  int bad   = 0;
  int busyc = 0;
  int viol  = 0;

  assign io_bus = tb_oe ? tb_d : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (io_bus[i]);
  end

  flash_core_cmd_ctrl #(
    .ADDR_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .fc_clk  (clk),
    .fc_rst  (rst),
    .nEN     (nEN),
    .nWE     (nWE),
    .nRE     (nRE),
    .nReset  (nReset),
    .Addr    (Addr),
    .IO      (io_bus),
    .fc_busy (fc_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fc_busy) busyc++;
    if (mon && io_bus !== 8'hFF) viol++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a,
                           input logic [7:0]  d);
    @(negedge clk);
    nEN = 0; Addr = a; tb_d = d; tb_oe = 1; nWE = 0;
    idle(4);
    nWE = 1;
    idle(4);
    tb_oe = 0; nEN = 1;
    idle(4);
  endtask

  task automatic unlock(input logic [7:0] op);
    bus_write(16'h5555, 8'hAA);
    bus_write(16'hAAAA, 8'h55);
    bus_write(16'h5555, op);
  endtask

  // lo: during nRE low, hi: after nRE rise, rel: after next nEN fall
  task automatic bus_read(input  logic [15:0] a,
                          output logic [7:0]  lo,
                          output logic [7:0]  hi,
                          output logic [7:0]  rel);
    @(negedge clk);
    nEN = 0; Addr = a; nRE = 0;
    idle(5);
    lo = io_bus;
    nRE = 1;
    idle(4);
    hi = io_bus;
    nEN = 1;
    idle(4);
    nEN = 0;
    idle(5);
    rel = io_bus;
    nEN = 1;
    idle(4);
  endtask

  task automatic test_reset;
    idle(4);
    vec++;
    if (io_bus !== 8'hFF) begin
      bad++;
      $display("FAIL reset_io got %h want ff", io_bus);
    end
    vec++;
    if (fc_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got %b want 0", fc_busy);
    end
    vec++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL reset_state got %0d want %0d",
               dut.state, IDLE);
    end
    @(negedge clk);
    rst = 0;
    idle(2);
  endtask

  task automatic test_program;
    int b0;
    logic [7:0] lo, hi, rel;
    b0 = busyc;
    unlock(OP_WRITE);
    bus_write(16'h1234, 8'h3C);
    vec++;
    if (busyc - b0 != 1) begin
      bad++;
      $display("FAIL prog_busy got %0d want 1", busyc - b0);
    end
    unlock(OP_READ);
    bus_read(16'h1234, lo, hi, rel);
    vec++;
    if (lo !== 8'h3C) begin
      bad++;
      $display("FAIL read_lo got %h want 3c", lo);
    end
    vec++;
    if (hi !== 8'h3C) begin
      bad++;
      $display("FAIL read_hi got %h want 3c", hi);
    end
    vec++;
    if (rel !== 8'hFF) begin
      bad++;
      $display("FAIL read_rel got %h want ff", rel);
    end
    vec++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL read_state got %0d want %0d",
               dut.state, IDLE);
    end
  endtask

  task automatic test_prog_mode;
    logic [7:0] lo, hi, rel;
`ifdef FC_PROG_AND_EN
    dut.u_mem.mem[16'h1234] = 8'hF0;
    unlock(OP_WRITE);
    bus_write(16'h1234, 8'h3C);
    unlock(OP_READ);
    bus_read(16'h1234, lo, hi, rel);
    vec++;
    if (lo !== 8'h30) begin
      bad++;
      $display("FAIL and_prog got %h want 30", lo);
    end
`else
    unlock(OP_WRITE);
    bus_write(16'h1234, 8'hF0);
    unlock(OP_READ);
    bus_read(16'h1234, lo, hi, rel);
    vec++;
    if (lo !== 8'hF0) begin
      bad++;
      $display("FAIL ovw_f0 got %h want f0", lo);
    end
`endif
    unlock(OP_WRITE);
    bus_write(16'h1234, 8'h3C);
    unlock(OP_READ);
    bus_read(16'h1234, lo, hi, rel);
`ifdef FC_PROG_AND_EN
    vec++;
    if (lo !== 8'h30) begin
      bad++;
      $display("FAIL and_again got %h want 30", lo);
    end
    dut.u_mem.mem[16'h1234] = 8'h3C;
`else
    vec++;
    if (lo !== 8'h3C) begin
      bad++;
      $display("FAIL ovw_3c got %h want 3c", lo);
    end
`endif
  endtask

  task automatic test_bad_unlock;
    logic [7:0] lo, hi, rel;
    bus_write(16'h5555, 8'hAA);
    bus_write(16'hAAAA, 8'h56);
    vec++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL bad_unlk_state got %0d want %0d",
               dut.state, IDLE);
    end
    unlock(OP_READ);
    bus_read(16'h1234, lo, hi, rel);
    vec++;
    if (lo !== 8'h3C) begin
      bad++;
      $display("FAIL bad_unlk_read got %h want 3c", lo);
    end
  endtask

  task automatic test_nreset_abort;
    int b0;
    logic [7:0] lo, hi, rel;
    unlock(OP_WRITE);
    vec++;
    if (dut.state !== WR_ARM) begin
      bad++;
      $display("FAIL arm_state got %0d want %0d",
               dut.state, WR_ARM);
    end
    @(negedge clk);
    nReset = 0;
    idle(5);
    nReset = 1;
    idle(4);
    vec++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL nrst_state got %0d want %0d",
               dut.state, IDLE);
    end
    b0 = busyc;
    bus_write(16'h1234, 8'h00);
    vec++;
    if (busyc != b0) begin
      bad++;
      $display("FAIL nrst_busy got %0d want 0", busyc - b0);
    end
    unlock(OP_READ);
    bus_read(16'h1234, lo, hi, rel);
    vec++;
    if (lo !== 8'h3C) begin
      bad++;
      $display("FAIL nrst_mem got %h want 3c", lo);
    end
  endtask

  task automatic test_no_unlock_read;
    int v0;
    logic [7:0] lo, hi, rel;
    v0 = viol;
    mon = 1;
    bus_read(16'h1234, lo, hi, rel);
    mon = 0;
    vec++;
    if (viol != v0) begin
      bad++;
      $display("FAIL nounlk_io got %0d driven cycles want 0",
               viol - v0);
    end
  endtask

  task automatic test_both_low;
    int v0;
    unlock(OP_READ);
    v0 = viol;
    @(negedge clk);
    mon = 1;
    nEN = 0; Addr = 16'h1234; nWE = 0; nRE = 0;
    idle(6);
    nWE = 1; nRE = 1;
    idle(5);
    mon = 0;
    nEN = 1;
    idle(4);
    vec++;
    if (viol != v0) begin
      bad++;
      $display("FAIL both_low_io got %0d driven cycles want 0",
               viol - v0);
    end
    vec++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL both_low_state got %0d want %0d",
               dut.state, IDLE);
    end
  endtask

  task automatic test_rst_in_rd_drv;
    unlock(OP_READ);
    @(negedge clk);
    nEN = 0; Addr = 16'h1234; nRE = 0;
    idle(5);
    vec++;
    if (io_bus !== 8'h3C) begin
      bad++;
      $display("FAIL rdrv_io got %h want 3c", io_bus);
    end
    rst = 1;
    @(posedge clk);
    #1;
    vec++;
    if (io_bus !== 8'hFF) begin
      bad++;
      $display("FAIL rst_io got %h want ff", io_bus);
    end
    vec++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL rst_state got %0d want %0d",
               dut.state, IDLE);
    end
    vec++;
    if (fc_busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got %b want 0", fc_busy);
    end
    @(negedge clk);
    rst = 0; nRE = 1; nEN = 1;
    idle(6);
  endtask

  initial begin
    test_reset();
    test_program();
    test_prog_mode();
    test_bad_unlock();
    test_nreset_abort();
    test_no_unlock_read();
    test_both_low();
    test_rst_in_rd_drv();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule
